// File: rtl/shift_reg_seq_ctrl.sv
// Sequencing controller for the 4-bit universal shift register.
// Turns TX/RX commands into load/shift/hold cycles on the register, with
// valid/ready handshakes on the command, serial and response sides.
module shift_reg_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic             sout_bit,
    output logic             sout_valid,
    input  logic             sout_ready,
    input  logic             sin_bit,
    input  logic             sin_valid,
    output logic             sin_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_op,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_parallel_in,
    output logic             sr_serial_in,
    input  logic             sr_serial_out,
    input  logic [WIDTH-1:0] sr_parallel_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TX_SHIFT = 2'd1,
        RX_SHIFT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0]       MODE_LOAD  = 2'b00;
    localparam logic [1:0]       MODE_SHIFT = 2'b01;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             rsp_op_q, rsp_op_nx;

    // State, bit counter and response op registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rsp_op_q <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rsp_op_q <= rsp_op_nx;
        end
    end

    // Next state, handshake outputs and register control; the register has no
    // hold mode, so "hold" is a reload of its own output.
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        rsp_op_nx      = rsp_op_q;
        cmd_ready      = 1'b0;
        sout_valid     = 1'b0;
        sout_bit       = 1'b0;
        sin_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_op         = 1'b0;
        rsp_data       = '0;
        busy           = (state != IDLE);
        sr_mode        = MODE_LOAD;
        sr_parallel_in = sr_parallel_out;
        sr_serial_in   = 1'b0;

        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cnt_nx    = '0;
                    rsp_op_nx = cmd_op;
                    if (!cmd_op) begin
                        sr_parallel_in = cmd_data;
                        state_nx       = TX_SHIFT;
                    end else begin
                        state_nx = RX_SHIFT;
                    end
                end
            end
            TX_SHIFT: begin
                sout_valid = 1'b1;
                sout_bit   = sr_serial_out;
                if (abort) begin
                    state_nx = IDLE;
                end else if (sout_ready) begin
                    sr_mode = MODE_SHIFT;
                    cnt_nx  = cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state_nx = DONE;
                    end
                end
            end
            RX_SHIFT: begin
                sin_ready = 1'b1;
                if (abort) begin
                    state_nx = IDLE;
                end else if (sin_valid) begin
                    sr_mode      = MODE_SHIFT;
                    sr_serial_in = sin_bit;
                    cnt_nx       = cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_op    = rsp_op_q;
                rsp_data  = rsp_op_q ? sr_parallel_out : '0;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Bench for shift_reg_seq_ctrl: a behavioural shift register is attached to
// the sr_* ports, and every cycle is checked against a transaction-level model.
module tb_shift_reg_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, cmd_valid, cmd_op, abort, sout_ready, sin_bit, sin_valid, rsp_ready;
    logic [3:0] cmd_data;
    logic       cmd_ready, sout_bit, sout_valid, sin_ready, rsp_valid, rsp_op, busy, sr_serial_in;
    logic [3:0] rsp_data, sr_parallel_in;
    logic [1:0] sr_mode;
    logic [3:0] q;

    always #5 clk = ~clk;

    shift_reg_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .abort(abort),
        .sout_bit(sout_bit), .sout_valid(sout_valid), .sout_ready(sout_ready),
        .sin_bit(sin_bit), .sin_valid(sin_valid), .sin_ready(sin_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
        .busy(busy),
        .sr_mode(sr_mode), .sr_parallel_in(sr_parallel_in), .sr_serial_in(sr_serial_in),
        .sr_serial_out(q[0]), .sr_parallel_out(q)
    );

    // The 4-bit universal shift register the controller drives.
    always_ff @(posedge clk) begin
        if (!reset_n)              q <= 4'b0000;
        else if (sr_mode == 2'b00) q <= sr_parallel_in;
        else if (sr_mode == 2'b01) q <= {sr_serial_in, q[3:1]};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: an operation is active or a response pending;
    // TX keeps the bits still to send, RX counts bits collected so far.
    bit         m_active, m_pend, m_op;
    bit         tx_q[$];
    int         rx_n;
    logic [3:0] m_q;

    task automatic model_reset();
        m_active = 0; m_pend = 0; m_op = 0; rx_n = 0; m_q = 4'b0000;
        tx_q.delete();
    endtask

    // One clock cycle: drive inputs after the edge, check outputs, advance model.
    task automatic step(input logic rn, input logic cv, input logic cop, input logic [3:0] cd,
                        input logic ab, input logic sr, input logic sb, input logic sv,
                        input logic rr);
        @(posedge clk);
        #1;
        reset_n = rn; cmd_valid = cv; cmd_op = cop; cmd_data = cd; abort = ab;
        sout_ready = sr; sin_bit = sb; sin_valid = sv; rsp_ready = rr;
        #1;
        check_eq("q",          32'(q),          32'(m_q));
        check_eq("cmd_ready",  32'(cmd_ready),  32'(!m_active && !m_pend));
        check_eq("busy",       32'(busy),       32'(m_active || m_pend));
        check_eq("sout_valid", 32'(sout_valid), 32'(m_active && !m_op));
        check_eq("sin_ready",  32'(sin_ready),  32'(m_active && m_op));
        check_eq("rsp_valid",  32'(rsp_valid),  32'(m_pend));
        if (m_active && !m_op && tx_q.size() > 0)
            check_eq("sout_bit", 32'(sout_bit), 32'(tx_q[0]));
        if (m_pend) begin
            check_eq("rsp_op",   32'(rsp_op),   32'(m_op));
            check_eq("rsp_data", 32'(rsp_data), m_op ? 32'(m_q) : 32'd0);
        end
        if (!rn) begin
            model_reset();
        end else if (m_pend) begin
            if (rr) m_pend = 0;
        end else if (m_active) begin
            if (ab) begin
                m_active = 0;
            end else if (!m_op && sr) begin
                void'(tx_q.pop_front());
                m_q = m_q >> 1;
                if (tx_q.size() == 0) begin m_active = 0; m_pend = 1; end
            end else if (m_op && sv) begin
                m_q = {sb, m_q[3:1]};
                rx_n++;
                if (rx_n == 4) begin m_active = 0; m_pend = 1; end
            end
        end else if (cv) begin
            m_active = 1; m_op = cop;
            if (!cop) begin
                m_q = cd;
                tx_q.delete();
                for (int i = 0; i < 4; i++) tx_q.push_back(cd[i]);
            end else begin
                rx_n = 0;
            end
        end
    endtask

    task automatic idle_step();
        step(1, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    endtask

    logic [3:0] tx_word;
    logic [3:0] rx_bits;

    initial begin
        reset_n = 0; cmd_valid = 0; cmd_op = 0; cmd_data = 0; abort = 0;
        sout_ready = 0; sin_bit = 0; sin_valid = 0; rsp_ready = 0;
        repeat (2) @(posedge clk);
        model_reset();
        step(0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        idle_step();
        check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);

        // TX 1011 with sout_ready high: bits 1,1,0,1 then response.
        tx_word = 4'b1011;
        step(1, 1, 0, tx_word, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 4'h0, 0, 1, 0, 0, 0);
            check_eq("tp_tx_bit", 32'(sout_bit), 32'(tx_word[i]));
        end
        step(1, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        check_eq("tp_tx_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("tp_tx_rsp_data",  32'(rsp_data),  32'd0);

        // RX 0,1,1,1 -> 1110.
        rx_bits = 4'b1110;
        step(1, 1, 1, 4'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4'h0, 0, 0, rx_bits[i], 1, 0);
        step(1, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        check_eq("tp_rx_data", 32'(rsp_data), 32'hE);
        check_eq("tp_rx_op",   32'(rsp_op),   32'd1);

        // TX 0110 with a 3-cycle stall after bit 2.
        step(1, 1, 0, 4'b0110, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4'h0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4'h0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 4'h0, 0, 0, 0, 0, 0);
            check_eq("tp_stall_bit", 32'(sout_bit), 32'd1);
        end
        step(1, 0, 0, 4'h0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4'h0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        check_eq("tp_stall_rsp", 32'(rsp_valid), 32'd1);

        // RX aborted on the 2nd bit, then RX 1,0,0,0 -> 0001.
        step(1, 1, 1, 4'h0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 4'h0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 4'h0, 1, 0, 1, 1, 0);
        idle_step();
        check_eq("tp_abort_idle", 32'(cmd_ready), 32'd1);
        rx_bits = 4'b0001;
        step(1, 1, 1, 4'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4'h0, 0, 0, rx_bits[i], 1, 0);
        step(1, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        check_eq("tp_abort_rx_data", 32'(rsp_data), 32'h1);

        // Reset in TX_SHIFT after one bit.
        step(1, 1, 0, 4'b1111, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4'h0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
        idle_step();
        check_eq("tp_reset_q",    32'(q),          32'd0);
        check_eq("tp_reset_sout", 32'(sout_valid), 32'd0);

        // Response held for 5 cycles with a command waiting.
        step(1, 1, 0, 4'b1001, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4'h0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 4'h0, 0, 0, 0, 0, 0);
            check_eq("tp_hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        step(1, 1, 1, 4'h0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 4'h0, 0, 0, 0, 0, 0);
        check_eq("tp_hold_accept", 32'(cmd_ready), 32'd1);
        idle_step();
        check_eq("tp_hold_busy", 32'(busy), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
